// File: rtl/display_pkg.sv
// Shared types, constants and helpers for the scoreboard digit scanner.
package display_pkg;

    // Widest bus and digit the slice helper handles
    localparam int unsigned MAX_BUS_W   = 1024;
    localparam int unsigned MAX_DIGIT_W = 32;

    // Code driven on digit_out while a channel is blanked
    localparam int unsigned BLANK_CODE = 0;

    // Counter width for a range of n values, never narrower than one bit
    function automatic int unsigned cnt_w(input int unsigned n);
        int unsigned c;
        c = $clog2(n);
        return (c < 1) ? 1 : c;
    endfunction

    // Extract channel k (w bits wide) from a packed digit bus
    function automatic logic [MAX_DIGIT_W-1:0] chan_slice(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          k,
        input int unsigned          w
    );
        logic [MAX_BUS_W-1:0]   sh;
        logic [MAX_DIGIT_W-1:0] res;
        sh  = bus >> (k * w);
        res = '0;
        for (int unsigned b = 0; b < MAX_DIGIT_W; b++) begin
            if (b < w) res[b] = sh[b];
        end
        return res;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Refresh prescaler: pulses tick once every PRESCALE enabled cycles.
module tick_gen
    import display_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int unsigned         PCNT_W = cnt_w(PRESCALE);
    localparam logic [PCNT_W-1:0]   LAST   = PCNT_W'(PRESCALE - 1);

    logic [PCNT_W-1:0] pcnt;

    // Tick in the last cycle of each slot; frozen while disabled
    assign tick = en && (pcnt == LAST);

    // Prescale counter, wraps to zero on tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= tick ? '0 : pcnt + PCNT_W'(1);
        end
    end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed digit scanner with frame-aligned double buffering.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DIGIT_W  = 4,
    parameter int unsigned PRESCALE = 50000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CHANNELS*DIGIT_W-1:0] digits,
    input  logic                        load,
    input  logic [CHANNELS-1:0]         blank_mask,
    input  logic                        hold,
    output logic [DIGIT_W-1:0]          digit_out,
    output logic [CHANNELS-1:0]         anode,
    output logic                        pending,
    output logic                        frame_done
);

    localparam int unsigned IDX_W = cnt_w(CHANNELS);
    localparam int unsigned BUS_W = CHANNELS * DIGIT_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    logic               scan_en;
    logic               tick;
    logic               wrap;
    logic [IDX_W-1:0]   idx;
    logic [BUS_W-1:0]   pend_reg;
    logic [BUS_W-1:0]   shadow_reg;
    logic               pend_flag;
    logic [DIGIT_W-1:0] digit_nxt;
    logic [CHANNELS-1:0] anode_nxt;

    assign scan_en = ~hold;
    assign wrap    = tick && (idx == LAST_IDX);
    assign pending = pend_flag;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (scan_en),
        .tick  (tick)
    );

    // Channel index, advances once per slot and wraps at end of frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (tick) begin
            idx <= wrap ? '0 : idx + IDX_W'(1);
        end
    end

    // Double buffer: a wrap moves the old pending data before a same-cycle load lands
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_reg   <= '0;
            shadow_reg <= '0;
            pend_flag  <= 1'b0;
        end else begin
            if (wrap && pend_flag) begin
                shadow_reg <= pend_reg;
            end
            if (load) begin
                pend_reg  <= digits;
                pend_flag <= 1'b1;
            end else if (wrap) begin
                pend_flag <= 1'b0;
            end
        end
    end

    // Next digit/anode from the current slot; blanking is applied live
    always_comb begin
        digit_nxt = DIGIT_W'(BLANK_CODE);
        anode_nxt = '0;
        if (!blank_mask[idx]) begin
            digit_nxt = DIGIT_W'(chan_slice(MAX_BUS_W'(shadow_reg), int'(idx), DIGIT_W));
            anode_nxt = CHANNELS'(1) << idx;
        end
    end

    // Registered display outputs and end-of-frame pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_out  <= '0;
            anode      <= '0;
            frame_done <= 1'b0;
        end else begin
            digit_out  <= digit_nxt;
            anode      <= anode_nxt;
            frame_done <= wrap;
        end
    end

endmodule
